// File: rtl/reg_file.sv
// reg_file: architectural register file with rename tags for the Tomasulo core.
//
// Answers two combinational source-operand lookups per cycle (data, busy,
// producing ROB id), records the destination rename on issue and retires
// values on ROB commit. A rollback clears every rename.
//
// Ports:
//   clk, rst             core clock (rising edge), asynchronous active-high reset
//   rdy                  global ready; all state holds while low
//   rollback             misprediction flush: clears all busy bits and tags
//   query_rs{1,2}_valid  source lookup request
//   query_rs{1,2}        source register index
//   rs{1,2}_data         architectural value (0 when the query is invalid)
//   rs{1,2}_busy         register awaits an in-flight producer
//   rs{1,2}_rob_id       tag of that producer
//   issue_valid/rd/rob_id           destination rename from the decoder
//   commit_valid/rd/rob_id/data     retirement from the ROB
//   busy_count           registered population count of busy registers
//
// Optional feature: define REGFILE_COMMIT_BYPASS_EN to forward a matching
// same-cycle commit onto the read ports (data = commit_data, busy = 0).
// Without it, reads reflect registered state only.

`timescale 1ns / 1ps

module reg_file #(
  parameter int unsigned REG_NUM      = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ROB_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,

  input  logic                    query_rs1_valid,
  input  logic [4:0]              query_rs1,
  input  logic                    query_rs2_valid,
  input  logic [4:0]              query_rs2,

  output logic [DATA_WIDTH-1:0]   rs1_data,
  output logic                    rs1_busy,
  output logic [ROB_ID_WIDTH-1:0] rs1_rob_id,
  output logic [DATA_WIDTH-1:0]   rs2_data,
  output logic                    rs2_busy,
  output logic [ROB_ID_WIDTH-1:0] rs2_rob_id,

  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic [ROB_ID_WIDTH-1:0] issue_rob_id,

  input  logic                    commit_valid,
  input  logic [4:0]              commit_rd,
  input  logic [ROB_ID_WIDTH-1:0] commit_rob_id,
  input  logic [DATA_WIDTH-1:0]   commit_data,

  output logic [5:0]              busy_count
);

  logic [DATA_WIDTH-1:0]   data_q [REG_NUM];
  logic [DATA_WIDTH-1:0]   data_d [REG_NUM];
  logic [ROB_ID_WIDTH-1:0] tag_q  [REG_NUM];
  logic [ROB_ID_WIDTH-1:0] tag_d  [REG_NUM];
  logic [REG_NUM-1:0]      busy_q;
  logic [REG_NUM-1:0]      busy_d;
  logic [5:0]              count_d;

  // Next-state of the rename table. Ordering matters: commit first, then
  // rollback/issue, so that issue overrides a same-register commit's busy clear.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;

    if (commit_valid && (commit_rd != 5'd0)) begin
      data_d[commit_rd] = commit_data;
      // A mismatching tag means a younger producer already owns the register.
      if (tag_q[commit_rd] == commit_rob_id) begin
        busy_d[commit_rd] = 1'b0;
      end
    end

    if (rollback) begin
      busy_d = '0;
      for (int i = 0; i < REG_NUM; i++) begin
        tag_d[i] = '0;
      end
    end else if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_rob_id;
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      count_d = count_d + 6'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q     <= '0;
      busy_count <= '0;
    end else if (rdy) begin
      data_q     <= data_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      busy_count <= count_d;
    end
  end

  // Read port 1
  always_comb begin
    rs1_data   = '0;
    rs1_busy   = 1'b0;
    rs1_rob_id = '0;
    if (query_rs1_valid && (query_rs1 != 5'd0)) begin
      rs1_data   = data_q[query_rs1];
      rs1_busy   = busy_q[query_rs1];
      rs1_rob_id = tag_q[query_rs1];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (busy_q[query_rs1] && commit_valid && (commit_rd == query_rs1) &&
          (commit_rob_id == tag_q[query_rs1]) && rdy && !rollback) begin
        rs1_data = commit_data;
        rs1_busy = 1'b0;
      end
`endif
    end
  end

  // Read port 2
  always_comb begin
    rs2_data   = '0;
    rs2_busy   = 1'b0;
    rs2_rob_id = '0;
    if (query_rs2_valid && (query_rs2 != 5'd0)) begin
      rs2_data   = data_q[query_rs2];
      rs2_busy   = busy_q[query_rs2];
      rs2_rob_id = tag_q[query_rs2];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (busy_q[query_rs2] && commit_valid && (commit_rd == query_rs2) &&
          (commit_rob_id == tag_q[query_rs2]) && rdy && !rollback) begin
        rs2_data = commit_data;
        rs2_busy = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
// Inputs change 1 ns after a rising edge; outputs are sampled mid-cycle.

`timescale 1ns / 1ps

module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        query_rs1_valid;
  logic [4:0]  query_rs1;
  logic        query_rs2_valid;
  logic [4:0]  query_rs2;
  logic [31:0] rs1_data;
  logic        rs1_busy;
  logic [3:0]  rs1_rob_id;
  logic [31:0] rs2_data;
  logic        rs2_busy;
  logic [3:0]  rs2_rob_id;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_id;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_rob_id;
  logic [31:0] commit_data;
  logic [5:0]  busy_count;

  int checks;
  int errors;

  reg_file #(
    .REG_NUM     (32),
    .DATA_WIDTH  (32),
    .ROB_ID_WIDTH(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rollback       (rollback),
    .query_rs1_valid(query_rs1_valid),
    .query_rs1      (query_rs1),
    .query_rs2_valid(query_rs2_valid),
    .query_rs2      (query_rs2),
    .rs1_data       (rs1_data),
    .rs1_busy       (rs1_busy),
    .rs1_rob_id     (rs1_rob_id),
    .rs2_data       (rs2_data),
    .rs2_busy       (rs2_busy),
    .rs2_rob_id     (rs2_rob_id),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_rob_id   (issue_rob_id),
    .commit_valid   (commit_valid),
    .commit_rd      (commit_rd),
    .commit_rob_id  (commit_rob_id),
    .commit_data    (commit_data),
    .busy_count     (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    commit_valid = 1'b0;
    rollback     = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [3:0] id);
    issue_valid  = 1'b1;
    issue_rd     = rd;
    issue_rob_id = id;
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [3:0] id, input logic [31:0] d);
    commit_valid  = 1'b1;
    commit_rd     = rd;
    commit_rob_id = id;
    commit_data   = d;
  endtask

  task automatic read1(input string tag, input logic [4:0] idx, input logic [31:0] d,
                       input logic b, input logic [3:0] id);
    query_rs1_valid = 1'b1;
    query_rs1       = idx;
    #1;
    check({tag, ".data"}, rs1_data, d);
    check({tag, ".busy"}, 32'(rs1_busy), 32'(b));
    check({tag, ".rob_id"}, 32'(rs1_rob_id), 32'(id));
  endtask

  task automatic read2(input string tag, input logic [4:0] idx, input logic [31:0] d,
                       input logic b, input logic [3:0] id);
    query_rs2_valid = 1'b1;
    query_rs2       = idx;
    #1;
    check({tag, ".data"}, rs2_data, d);
    check({tag, ".busy"}, 32'(rs2_busy), 32'(b));
    check({tag, ".rob_id"}, 32'(rs2_rob_id), 32'(id));
  endtask

  task automatic check_count(input string tag, input logic [5:0] exp);
    check(tag, 32'(busy_count), 32'(exp));
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    rdy             = 1'b1;
    rollback        = 1'b0;
    query_rs1_valid = 1'b0;
    query_rs1       = '0;
    query_rs2_valid = 1'b0;
    query_rs2       = '0;
    issue_valid     = 1'b0;
    issue_rd        = '0;
    issue_rob_id    = '0;
    commit_valid    = 1'b0;
    commit_rd       = '0;
    commit_rob_id   = '0;
    commit_data     = '0;

    // Reset state
    #3;
    read1("reset_x5", 5'd5, 32'h0, 1'b0, 4'd0);
    check_count("reset_count", 6'd0);
    tick();
    tick();
    rst = 1'b0;

    // Issue x5 tag 3, then commit it
    do_issue(5'd5, 4'd3);
    tick();
    idle();
    read1("issue_x5", 5'd5, 32'h0, 1'b1, 4'd3);
    check_count("issue_count", 6'd1);
    do_commit(5'd5, 4'd3, 32'hDEADBEEF);
    tick();
    idle();
    read1("commit_x5", 5'd5, 32'hDEADBEEF, 1'b0, 4'd3);
    check_count("commit_count", 6'd0);

    // Stale commit: younger rename of x7 survives
    do_issue(5'd7, 4'd2);
    tick();
    do_issue(5'd7, 4'd9);
    tick();
    idle();
    do_commit(5'd7, 4'd2, 32'h11);
    tick();
    idle();
    read2("stale_x7", 5'd7, 32'h11, 1'b1, 4'd9);
    check_count("stale_count", 6'd1);

    // Invalid query reads zero even for a busy register
    query_rs2_valid = 1'b0;
    #1;
    check("invalid_q.data", rs2_data, 32'h0);
    check("invalid_q.busy", 32'(rs2_busy), 32'd0);
    check("invalid_q.rob_id", 32'(rs2_rob_id), 32'd0);

    // x0 ignores issue and commit
    do_issue(5'd0, 4'd4);
    do_commit(5'd0, 4'd0, 32'h55);
    tick();
    idle();
    read1("x0", 5'd0, 32'h0, 1'b0, 4'd0);
    check_count("x0_count", 6'd1);

    // rdy=0 freezes state
    rdy = 1'b0;
    do_issue(5'd3, 4'd1);
    do_commit(5'd7, 4'd9, 32'h77);
    tick();
    idle();
    rdy = 1'b1;
    read1("rdy_x3", 5'd3, 32'h0, 1'b0, 4'd0);
    read2("rdy_x7", 5'd7, 32'h11, 1'b1, 4'd9);
    check_count("rdy_count", 6'd1);

    // Same-cycle issue and commit to x7: data written, issue owns busy/tag
    do_commit(5'd7, 4'd9, 32'h77);
    do_issue(5'd7, 4'd12);
    tick();
    idle();
    read2("iss_com_x7", 5'd7, 32'h77, 1'b1, 4'd12);
    check_count("iss_com_count", 6'd1);

    // Rollback with a matching commit and a dropped issue
    do_issue(5'd1, 4'd1);
    tick();
    do_issue(5'd2, 4'd2);
    tick();
    do_issue(5'd4, 4'd4);
    tick();
    idle();
    check_count("pre_rb_count", 6'd4);
    rollback = 1'b1;
    do_commit(5'd2, 4'd2, 32'h42);
    do_issue(5'd6, 4'd6);
    tick();
    idle();
    read1("rb_x2", 5'd2, 32'h42, 1'b0, 4'd0);
    read2("rb_x7", 5'd7, 32'h77, 1'b0, 4'd0);
    read1("rb_x6", 5'd6, 32'h0, 1'b0, 4'd0);
    read2("rb_x4", 5'd4, 32'h0, 1'b0, 4'd0);
    check_count("rb_count", 6'd0);

    // Same-cycle commit visibility on a busy register
    do_issue(5'd8, 4'd5);
    tick();
    idle();
    do_commit(5'd8, 4'd5, 32'h99);
`ifdef REGFILE_COMMIT_BYPASS_EN
    read1("bypass_x8", 5'd8, 32'h99, 1'b0, 4'd5);
`else
    read1("nobypass_x8", 5'd8, 32'h0, 1'b1, 4'd5);
`endif
    tick();
    idle();
    read1("post_commit_x8", 5'd8, 32'h99, 1'b0, 4'd5);
    check_count("post_commit_count", 6'd0);

    // Asynchronous reset mid-cycle with x5 busy
    do_issue(5'd5, 4'd3);
    tick();
    idle();
    read1("pre_rst_x5", 5'd5, 32'hDEADBEEF, 1'b1, 4'd3);
    check_count("pre_rst_count", 6'd1);
    rst = 1'b1;
    read1("async_rst_x5", 5'd5, 32'h0, 1'b0, 4'd0);
    read2("async_rst_x7", 5'd7, 32'h0, 1'b0, 4'd0);
    check_count("async_rst_count", 6'd0);
    tick();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags for the Tomasulo core.
- Responder end of the decoder's register query: answers two combinational source-operand lookups per cycle (data, busy, producing ROB id).
- Records the destination rename on issue and retires values on ROB commit.
- Sits between the decoder (queries and renames) and the ROB (commits and rollback).

Parameters:
- REG_NUM, 32, number of architectural registers (x0..x31).
- DATA_WIDTH, 32, register data width.
- ROB_ID_WIDTH, 4, width of a ROB entry tag (16-entry ROB).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; when 0 all state holds.
- rollback  in  1  misprediction flush from the ROB.
- query_rs1_valid  in  1  decoder requests rs1 lookup.
- query_rs1  in  5  rs1 register index.
- query_rs2_valid  in  1  decoder requests rs2 lookup.
- query_rs2  in  5  rs2 register index.
- rs1_data  out  DATA_WIDTH  architectural value of rs1.
- rs1_busy  out  1  rs1 awaits an in-flight producer.
- rs1_rob_id  out  ROB_ID_WIDTH  tag of the rs1 producer.
- rs2_data  out  DATA_WIDTH  architectural value of rs2.
- rs2_busy  out  1  rs2 awaits an in-flight producer.
- rs2_rob_id  out  ROB_ID_WIDTH  tag of the rs2 producer.
- issue_valid  in  1  decoder issues an instruction with a destination.
- issue_rd  in  5  destination register.
- issue_rob_id  in  ROB_ID_WIDTH  ROB entry allocated to the destination.
- commit_valid  in  1  ROB retires an instruction with a destination.
- commit_rd  in  5  retired destination.
- commit_rob_id  in  ROB_ID_WIDTH  tag of the retiring entry.
- commit_data  in  DATA_WIDTH  retired value.
- busy_count  out  6  number of registers currently busy.

Behaviour:
- State per register: data[DATA_WIDTH], busy, tag[ROB_ID_WIDTH].
- Reset (async, rst=1): all data=0, busy=0, tag=0, busy_count=0. Read outputs then report 0/0/0.
- Reads are combinational.
  - Query valid: outputs data[idx], busy[idx], tag[idx].
  - Query invalid: outputs 0/0/0.
- x0: always reads data 0, busy 0, tag 0. Issue and commit to x0 are ignored.
- All updates occur on the rising edge of clk, and only when rdy=1. When rdy=0, state is frozen; reads still answer from held state.
- Commit (commit_valid, commit_rd!=0):
  - data[rd] <= commit_data.
  - busy[rd] <= 0 only if tag[rd]==commit_rob_id. Otherwise a younger producer owns rd and busy/tag are unchanged.
- Issue (issue_valid, issue_rd!=0): busy[rd] <= 1, tag[rd] <= issue_rob_id.
- Issue and commit to the same rd in one cycle: the data write takes effect, and busy=1 with tag=issue_rob_id (issue wins).
- Rollback=1:
  - All busy <= 0 and all tags <= 0.
  - A commit in the same cycle still writes its data.
  - Issue is ignored.
- busy_count: registered. Recomputed each update cycle as the next-state population count of busy. Range 0..31.
- No internal FSM beyond per-register state; latency from issue or commit to a visible read is 1 cycle.

Optional Feature:
- Macro: REGFILE_COMMIT_BYPASS_EN.
- Defined: a query hits the bypass when the register is busy, commit_valid=1, commit_rd==idx, commit_rob_id==tag[idx], rdy=1 and rollback=0. On a hit the read returns data=commit_data and busy=0 in the same cycle.
- Undefined: reads reflect registered state only. The queried register reports busy=1 with the old tag, and the decoder resolves the value through the ROB.

Test Plan:
- Reset: assert rst mid-run with x5 busy -> asynchronously all reads 0/0/0 and busy_count=0.
- Issue then commit:
  - Issue x5 tag 3 -> next cycle rs1=x5 reads busy=1, rob_id=3, busy_count=1.
  - Commit x5 tag 3 data 0xDEADBEEF -> next cycle busy=0, data=0xDEADBEEF, busy_count=0.
- Stale commit: issue x7 tag 2, then issue x7 tag 9, then commit x7 tag 2 data 0x11 -> data=0x11, busy=1, rob_id=9.
- x0 and rdy:
  - Issue or commit to x0 with data 0x55 -> x0 reads 0/0/0.
  - With rdy=0, issue x3 tag 1 -> x3 stays not busy.
- Rollback: x1, x2, x4 busy; rollback plus commit x2 tag match data 0x42 -> all busy=0, x2 data=0x42, busy_count=0; a simultaneous issue of x6 is dropped.
- Bypass (macro defined): x8 busy tag 5; same cycle commit x8 tag 5 data 0x99 and query x8 -> rs1_data=0x99, rs1_busy=0. With the macro undefined -> rs1_busy=1, rs1_rob_id=5.
